fetch_exec_controller: RTL

FETCH_EXEC_CONTROLLER -- requirements
Module: fetch_exec_controller

---
 rtl/fetch_exec_controller.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/fetch_exec_controller.sv
// Two-byte instruction fetch, decode and execute sequencer driving IR, PC and R0..R3 controls.
// Latency: 2 cycles per fetched byte (request + acknowledge), then 1 DECODE and 1 EXEC cycle; all outputs registered.
// Backpressure: each fetch byte waits on mem_ready for up to TIMEOUT cycles, after which the block locks in FAULT.
//
// Optional feature macro: STEP_MODE_EN adds input `step` and a STEP_WAIT state after every non-HALT EXEC.
// Ports:
//   clock, reset (async, active high), start, [step], mem_ready, ir_in[15:0]  -- inputs
//   mem_rd                                 -- memory read request
//   ir_enable, ir_funsel[1:0], ir_lh       -- IR load controls (lh=0 low byte, lh=1 high byte)
//   pc_enable, pc_funsel[1:0]              -- PC controls (11 = increment)
//   reg_enable[3:0], reg_funsel[1:0], reg_load[7:0] -- R0..R3 controls
//   busy, halted, fault, illegal_op        -- status flags

module fetch_exec_controller #(
    parameter int TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
`ifdef STEP_MODE_EN
    input  logic        step,
`endif
    input  logic        mem_ready,
    input  logic [15:0] ir_in,
    output logic        mem_rd,
    output logic        ir_enable,
    output logic [1:0]  ir_funsel,
    output logic        ir_lh,
    output logic        pc_enable,
    output logic [1:0]  pc_funsel,
    output logic [3:0]  reg_enable,
    output logic [1:0]  reg_funsel,
    output logic [7:0]  reg_load,
    output logic        busy,
    output logic        halted,
    output logic        fault,
    output logic        illegal_op
);

`ifdef STEP_MODE_EN
    typedef enum logic [2:0] {IDLE, FETCH_L, FETCH_H, DECODE, EXEC, HALTED, FAULT, STEP_WAIT} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH_L, FETCH_H, DECODE, EXEC, HALTED, FAULT} state_t;
`endif

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  dst_q, dst_d;
    logic [7:0]  imm_q, imm_d;

    logic        mem_rd_d, ir_enable_d, ir_lh_d, pc_enable_d;
    logic [1:0]  ir_funsel_d, pc_funsel_d, reg_funsel_d;
    logic [3:0]  reg_enable_d;
    logic [7:0]  reg_load_d;
    logic        busy_d, halted_d, fault_d, illegal_d;

    // ir_in[9:8] carry no meaning for this instruction set.
    logic unused_ir;
    assign unused_ir = ^ir_in[9:8];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            op_q       <= '0;
            dst_q      <= '0;
            imm_q      <= '0;
            mem_rd     <= 1'b0;
            ir_enable  <= 1'b0;
            ir_funsel  <= '0;
            ir_lh      <= 1'b0;
            pc_enable  <= 1'b0;
            pc_funsel  <= '0;
            reg_enable <= '0;
            reg_funsel <= '0;
            reg_load   <= '0;
            busy       <= 1'b0;
            halted     <= 1'b0;
            fault      <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            op_q       <= op_d;
            dst_q      <= dst_d;
            imm_q      <= imm_d;
            mem_rd     <= mem_rd_d;
            ir_enable  <= ir_enable_d;
            ir_funsel  <= ir_funsel_d;
            ir_lh      <= ir_lh_d;
            pc_enable  <= pc_enable_d;
            pc_funsel  <= pc_funsel_d;
            reg_enable <= reg_enable_d;
            reg_funsel <= reg_funsel_d;
            reg_load   <= reg_load_d;
            busy       <= busy_d;
            halted     <= halted_d;
            fault      <= fault_d;
            illegal_op <= illegal_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        op_d         = op_q;
        dst_d        = dst_q;
        imm_d        = imm_q;
        mem_rd_d     = 1'b0;
        ir_enable_d  = 1'b0;
        ir_funsel_d  = 2'b00;
        ir_lh_d      = 1'b0;
        pc_enable_d  = 1'b0;
        pc_funsel_d  = 2'b00;
        reg_enable_d = 4'b0000;
        reg_funsel_d = 2'b00;
        reg_load_d   = 8'h00;
        illegal_d    = illegal_op;

        case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    state_d  = FETCH_L;
                    mem_rd_d = 1'b1;
                    wait_d   = '0;
                end
            end
            FETCH_L, FETCH_H: begin
                // Each fetch state has a request phase (mem_rd high) and a
                // one-cycle acknowledge phase carrying the IR/PC pulse.
                if (mem_rd) begin
                    if (mem_ready) begin
                        ir_enable_d = 1'b1;
                        ir_funsel_d = 2'b01;
                        ir_lh_d     = (state_q == FETCH_H);
                        pc_enable_d = 1'b1;
                        pc_funsel_d = 2'b11;
                    end else if (wait_q == WAIT_LAST) begin
                        state_d = FAULT;
                    end else begin
                        wait_d   = wait_q + 8'd1;
                        mem_rd_d = 1'b1;
                    end
                end else begin
                    wait_d = '0;
                    if (state_q == FETCH_L) begin
                        state_d  = FETCH_H;
                        mem_rd_d = 1'b1;
                    end else begin
                        state_d = DECODE;
                    end
                end
            end
            DECODE: begin
                // The high-byte IR load has landed by now, so ir_in is complete.
                op_d    = ir_in[15:12];
                dst_d   = ir_in[11:10];
                imm_d   = ir_in[7:0];
                state_d = EXEC;
            end
            EXEC: begin
                if (op_q == 4'd4) begin
                    state_d = HALTED;
                end else begin
                    if (op_q < 4'd4) begin
                        // CLR/LDI/DEC/INC map directly onto reg_funsel 00/01/10/11.
                        reg_enable_d = 4'b0001 << dst_q;
                        reg_funsel_d = op_q[1:0];
                        if (op_q == 4'd1) reg_load_d = imm_q;
                    end else begin
                        illegal_d = 1'b1;
                    end
`ifdef STEP_MODE_EN
                    state_d = STEP_WAIT;
`else
                    state_d  = FETCH_L;
                    mem_rd_d = 1'b1;
                    wait_d   = '0;
`endif
                end
            end
`ifdef STEP_MODE_EN
            STEP_WAIT: begin
                if (step) begin
                    state_d  = FETCH_L;
                    mem_rd_d = 1'b1;
                    wait_d   = '0;
                end
            end
`endif
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == FETCH_L) || (state_d == FETCH_H) ||
                 (state_d == DECODE) || (state_d == EXEC);
`ifdef STEP_MODE_EN
        if (state_d == STEP_WAIT) busy_d = 1'b1;
`endif
        halted_d = (state_d == HALTED);
        fault_d  = (state_d == FAULT);
    end

endmodule
